// File: rtl/restoring_divider_seq_if.sv
// Start/done handshake bundle for the sequential restoring divider.
interface restoring_divider_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Requester side: issues operands and start, observes results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_seq.sv
// Iterative unsigned restoring divider: one trial subtract and one quotient
// bit per clock. Divide-by-zero short-circuits straight to DONE.
module restoring_divider_seq #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    restoring_divider_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH:0]   r_q;      // partial remainder, one guard bit for the borrow
    logic [WIDTH-1:0] q_q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;

    // One restoring step: shift in the next dividend bit, trial-subtract D,
    // keep the difference only when it did not borrow.
    always_comb begin
        rs = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        t  = rs + ~{1'b0, d_q} + ONE;
        if (!t[WIDTH]) begin
            r_d = t;
            q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            r_d = rs;
            q_d = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM with datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        r_q    <= '0;
                        q_q    <= bus.dividend;
                        d_q    <= bus.divisor;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (bus.divisor == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= bus.dividend;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= r_d[WIDTH-1:0];
                        dbz_q   <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
